program_memory: RTL and testbench
=================================

# program_memory

Byte-wide program/data memory that serves the processor's RAM bus: it accepts `ram_addr`, `ram_data` and `ram_we` from the core and returns `ram_out`. A valid/ready load port writes a program image before execution. While loading, the block holds the processor with `cpu_hold`, then releases it.

## Interface
Parameters:
- `ADDR_W`, default 8: address width. Depth is 2^ADDR_W (256).
- `DATA_W`, default 8: word width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ram_addr`  in  ADDR_W  processor address (driven from the core's MAR).
- `ram_data`  in  DATA_W  processor write data (driven from the core's MBR).
- `ram_we`  in  1  processor write enable.
- `ram_out`  out  DATA_W  registered read data to the core.
- `ld_start`  in  1  single-cycle request to re-enter LOAD from RUN.
- `ld_valid`  in  1  load byte valid.
- `ld_data`  in  DATA_W  load byte.
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  load port can accept a byte.
- `cpu_hold`  out  1  holds the processor; high for the whole of LOAD.
- `loaded_len`  out  ADDR_W+1  number of bytes written by the last load (0..256).

## Operation
- Two states: LOAD and RUN.
- Storage has no reset. Contents are undefined until written.
- **Reset values:**
  - state = LOAD, load pointer = 0.
  - `ram_out` = 0, `ld_ready` = 1, `cpu_hold` = 1, `loaded_len` = 0.
- **LOAD:**
  - `ld_ready` = 1 and `cpu_hold` = 1.
  - A transfer occurs on any edge where `ld_valid` && `ld_ready`. It writes `mem[ptr] <= ld_data`, increments `ptr`, and increments `loaded_len`.
  - The transfer is the last one when `ld_last` = 1 or `ptr` = 255. The state moves to RUN on the same edge.
  - On a pointer-255 termination, `ptr` wraps to 0. No byte is ever written past address 255.
  - Processor port is ignored: `ram_we` has no effect and `ram_out` holds 0.
  - `ld_start` is ignored.
- **RUN:**
  - `ld_ready` = 0 and `cpu_hold` = 0.
  - Every edge performs `ram_out <= mem[ram_addr]`.
  - If `ram_we` = 1, the same edge also performs `mem[ram_addr] <= ram_data`.
  - Read-before-write: when reading and writing the same address on one edge, `ram_out` returns the old contents.
  - Load-port signals are ignored.
- **`ld_start` in RUN:**
  - On that edge, any `ram_we` write still completes.
  - State goes to LOAD; `ptr` and `loaded_len` clear to 0; `ram_out` clears to 0.
- **Reset mid-LOAD:** restarts at `ptr` = 0. Bytes already written remain in storage but are not counted.

## Timing
- Read latency is 1 cycle: an address presented before edge N is visible on `ram_out` after edge N.
- Write latency is 1 cycle: data written at edge N is readable at edge N+1.
- `ld_ready` and `cpu_hold` are registered outputs decoded from state.
  - The LOAD→RUN transition at edge N makes `cpu_hold` fall after edge N.
  - The first valid processor read is therefore captured at edge N+1.
- Load throughput is 1 byte per cycle. `ld_ready` never stalls within LOAD.
- `ld_valid` with `ld_ready` = 0 is dropped. The source must hold `ld_valid`/`ld_data` until it sees `ld_ready` = 1.

## Structure
- Shared package `pm_pkg`:
  - `pm_state_t` enum {LOAD, RUN}.
  - Constants `PM_ADDR_W` = 8, `PM_DATA_W` = 8, `PM_DEPTH` = 256.
- One sub-module, `pm_ram_1rw`: a single-port synchronous array with read-before-write and no reset.
  - The top level muxes the port's address, data and write enable between the load pointer (in LOAD) and the processor bus (in RUN).
  - The top level holds the FSM, pointer, counters and output registers.

## Test plan
- Reset, then stream 4 bytes A0,A1,A2,A3 with `ld_last` on A3 → `loaded_len` = 4 and `cpu_hold` falls after the A3 edge. Reading addresses 0..3 in RUN returns A0..A3, each 1 cycle after its address.
- Stream 256 bytes with `ld_last` = 0 → LOAD auto-terminates after byte 255, `loaded_len` = 256, address 0 still holds byte 0 (no wrap overwrite).
- In RUN, write 0x5A to 0x10 with a same-cycle read of 0x10 → `ram_out` shows the old value. The next-cycle read of 0x10 returns 0x5A.
- In LOAD, drive `ram_we` = 1, `ram_addr` = 0x02, `ram_data` = 0xFF → no write occurs; after load, address 0x02 holds the loaded byte.
- In RUN, pulse `ld_start` together with a `ram_we` write of 0x33 to 0x40 → 0x40 = 0x33 is retained. `cpu_hold` = 1, `ld_ready` = 1, `ram_out` = 0, `loaded_len` = 0.
- Assert `rst_n` low after 2 bytes of a load → all outputs return to reset values immediately (asynchronous). A subsequent 1-byte load with `ld_last` writes address 0 and sets `loaded_len` = 1.

Source files
------------

// File: rtl/program_memory_pkg.sv
// rtl/program_memory_pkg.sv - shared types and constants for the program memory
package pm_pkg;

    localparam int PM_ADDR_W = 8;
    localparam int PM_DATA_W = 8;
    localparam int PM_DEPTH  = 256;

    // LOAD: image is being streamed in and the core is held; RUN: core owns the port
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } pm_state_t;

endpackage

// File: rtl/program_memory_if.sv
// rtl/program_memory_if.sv - processor RAM bus and image load port bundle
interface program_memory_if
    import pm_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W
);

    // processor RAM bus
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic [DATA_W-1:0] ram_out;

    // image load port
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;

    // status
    logic              cpu_hold;
    logic [ADDR_W:0]   loaded_len;

    // core / loader side
    modport master (
        output ram_addr, ram_data, ram_we, ld_start, ld_valid, ld_data, ld_last,
        input  ram_out, ld_ready, cpu_hold, loaded_len
    );

    // memory side
    modport slave (
        input  ram_addr, ram_data, ram_we, ld_start, ld_valid, ld_data, ld_last,
        output ram_out, ld_ready, cpu_hold, loaded_len
    );

endinterface

// File: rtl/program_memory_ram.sv
// rtl/program_memory_ram.sv - single-port synchronous RAM, read-before-write, no reset
module pm_ram_1rw
    import pm_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    output logic [DATA_W-1:0] rdata_q
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // read returns the pre-write contents when the same address is written on this edge
    always_ff @(posedge clk) begin
        rdata_q <= mem[addr];
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/program_memory.sv
// rtl/program_memory.sv - program/data memory with image loader and processor hold
module program_memory
    import pm_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int DATA_W = PM_DATA_W
) (
    input  logic           clk,
    input  logic           rst_n,
    program_memory_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    pm_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ld_ready_q, ld_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              rd_en_q, rd_en_d;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              xfer;

    pm_ram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .addr    (mem_addr),
        .wdata   (mem_wdata),
        .we      (mem_we),
        .rdata_q (mem_rdata)
    );

    // next-state, pointer/length update and RAM port steering between loader and core
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        rd_en_d   = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = bus.ld_data;
        mem_we    = 1'b0;
        xfer      = 1'b0;

        case (state_q)
            LOAD: begin
                xfer   = bus.ld_valid && ld_ready_q;
                mem_we = xfer;
                if (xfer) begin
                    ptr_d = ptr_q + PTR_ONE;
                    len_d = len_q + LEN_ONE;
                    // the top address always ends the image so nothing wraps over address 0
                    if (bus.ld_last || (ptr_q == '1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                mem_addr  = bus.ram_addr;
                mem_wdata = bus.ram_data;
                mem_we    = bus.ram_we;
                rd_en_d   = 1'b1;
                // a pending core write still lands; read data is suppressed to zero
                if (bus.ld_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    len_d   = '0;
                    rd_en_d = 1'b0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        ld_ready_d = (state_d == LOAD);
        cpu_hold_d = (state_d == LOAD);
    end

    // state, pointer, length and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            ptr_q      <= '0;
            len_q      <= '0;
            ld_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            ld_ready_q <= ld_ready_d;
            cpu_hold_q <= cpu_hold_d;
            rd_en_q    <= rd_en_d;
        end
    end

    // read data is only exposed after an edge that performed a processor read
    assign bus.ram_out    = rd_en_q ? mem_rdata : '0;
    assign bus.ld_ready   = ld_ready_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.loaded_len = len_q;

endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - directed self-checking bench for program_memory
module tb_program_memory;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    program_memory_if bus_if ();

    program_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // reference behaviour
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    bit         m_loading   = 1'b1;
    int         m_ptr       = 0;
    int         m_len       = 0;
    logic [7:0] m_out       = 8'h00;
    bit         m_out_known = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model of one clock edge (or asynchronous reset)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading   = 1'b1;
            m_ptr       = 0;
            m_len       = 0;
            m_out       = 8'h00;
            m_out_known = 1'b1;
        end else if (m_loading) begin
            m_out       = 8'h00;
            m_out_known = 1'b1;
            if (bus_if.ld_valid) begin
                m_mem[m_ptr]   = bus_if.ld_data;
                m_known[m_ptr] = 1'b1;
                m_len          = m_len + 1;
                if (bus_if.ld_last || m_ptr == 255) m_loading = 1'b0;
                m_ptr = (m_ptr + 1) % 256;
            end
        end else begin
            int a;
            a = int'(bus_if.ram_addr);
            m_out       = m_mem[a];
            m_out_known = m_known[a];
            if (bus_if.ram_we) begin
                m_mem[a]   = bus_if.ram_data;
                m_known[a] = 1'b1;
            end
            if (bus_if.ld_start) begin
                m_loading   = 1'b1;
                m_ptr       = 0;
                m_len       = 0;
                m_out       = 8'h00;
                m_out_known = 1'b1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ld_ready", int'(bus_if.ld_ready), int'(m_loading));
            chk("cyc_cpu_hold", int'(bus_if.cpu_hold), int'(m_loading));
            chk("cyc_loaded_len", int'(bus_if.loaded_len), m_len);
            if (m_out_known) chk("cyc_ram_out", int'(bus_if.ram_out), int'(m_out));
        end
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = d;
        bus_if.ld_last  = last;
        edge_();
        bus_if.ld_valid = 1'b0;
        bus_if.ld_last  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        bus_if.ram_we   = 1'b0;
        bus_if.ram_addr = a;
        edge_();
    endtask

    initial begin
        bus_if.ram_addr = '0;
        bus_if.ram_data = '0;
        bus_if.ram_we   = 1'b0;
        bus_if.ld_start = 1'b0;
        bus_if.ld_valid = 1'b0;
        bus_if.ld_data  = '0;
        bus_if.ld_last  = 1'b0;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

        #1 rst_n = 1'b0;
        edge_();
        edge_();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        chk("rst_ld_ready", int'(bus_if.ld_ready), 1);
        chk("rst_cpu_hold", int'(bus_if.cpu_hold), 1);
        chk("rst_loaded_len", int'(bus_if.loaded_len), 0);
        chk("rst_ram_out", int'(bus_if.ram_out), 0);

        // 4-byte image while the core tries to write 0xFF to 0x02
        bus_if.ram_we   = 1'b1;
        bus_if.ram_addr = 8'h02;
        bus_if.ram_data = 8'hFF;
        for (int i = 0; i < 4; i++) load_byte(8'hA0 + 8'(i), (i == 3));
        bus_if.ram_we = 1'b0;
        chk("load4_len", int'(bus_if.loaded_len), 4);
        chk("load4_hold", int'(bus_if.cpu_hold), 0);
        chk("load4_ready", int'(bus_if.ld_ready), 0);
        for (int i = 0; i < 4; i++) begin
            rd(8'(i));
            chk("load4_read", int'(bus_if.ram_out), 8'hA0 + i);
        end

        // read-before-write on the same address
        bus_if.ram_we = 1'b1; bus_if.ram_addr = 8'h10; bus_if.ram_data = 8'h11;
        edge_();
        bus_if.ram_data = 8'h5A;
        edge_();
        chk("rbw_old", int'(bus_if.ram_out), 8'h11);
        rd(8'h10);
        chk("rbw_new", int'(bus_if.ram_out), 8'h5A);

        // ld_start together with a core write
        bus_if.ram_we = 1'b1; bus_if.ram_addr = 8'h40; bus_if.ram_data = 8'h33;
        bus_if.ld_start = 1'b1;
        edge_();
        bus_if.ld_start = 1'b0;
        bus_if.ram_we   = 1'b0;
        chk("start_hold", int'(bus_if.cpu_hold), 1);
        chk("start_ready", int'(bus_if.ld_ready), 1);
        chk("start_out", int'(bus_if.ram_out), 0);
        chk("start_len", int'(bus_if.loaded_len), 0);
        load_byte(8'hC3, 1'b1);
        chk("one_len", int'(bus_if.loaded_len), 1);
        rd(8'h40);
        chk("start_wr_kept", int'(bus_if.ram_out), 8'h33);
        rd(8'h00);
        chk("one_byte", int'(bus_if.ram_out), 8'hC3);

        // full 256-byte image without ld_last
        bus_if.ld_start = 1'b1;
        edge_();
        bus_if.ld_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus_if.ld_valid = 1'b1;
            bus_if.ld_data  = 8'(i) ^ 8'h5C;
            bus_if.ld_last  = 1'b0;
            edge_();
        end
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = 8'hEE;
        chk("full_len", int'(bus_if.loaded_len), 256);
        chk("full_hold", int'(bus_if.cpu_hold), 0);
        rd(8'h00);
        bus_if.ld_valid = 1'b0;
        chk("full_addr0", int'(bus_if.ram_out), 8'h5C);
        rd(8'h01);
        chk("full_addr1", int'(bus_if.ram_out), 8'h5D);
        rd(8'hFF);
        chk("full_addr255", int'(bus_if.ram_out), 8'hA3);
        chk("full_len_kept", int'(bus_if.loaded_len), 256);

        // asynchronous reset in the middle of a load
        bus_if.ld_start = 1'b1;
        edge_();
        bus_if.ld_start = 1'b0;
        load_byte(8'h91, 1'b0);
        load_byte(8'h92, 1'b0);
        chk("mid_len", int'(bus_if.loaded_len), 2);
        rst_n = 1'b0;
        #1;
        chk("arst_len", int'(bus_if.loaded_len), 0);
        chk("arst_hold", int'(bus_if.cpu_hold), 1);
        chk("arst_ready", int'(bus_if.ld_ready), 1);
        chk("arst_out", int'(bus_if.ram_out), 0);
        edge_();
        rst_n = 1'b1;
        load_byte(8'h77, 1'b1);
        chk("post_rst_len", int'(bus_if.loaded_len), 1);
        rd(8'h00);
        chk("post_rst_addr0", int'(bus_if.ram_out), 8'h77);
        rd(8'h01);
        chk("post_rst_addr1", int'(bus_if.ram_out), 8'h92);
        edge_();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
